tetris_game_ctrl: RTL and testbench



---
 rtl/tetris_game_ctrl_if.sv | 34 +++
 rtl/tetris_game_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_tetris_game_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tetris_game_ctrl_if.sv
// Signal bundle between the game controller and its environment: debounced buttons
// and core status in, core reset, gravity tick, move commands and status out.
interface tetris_game_ctrl_if;
  logic       btn_left;
  logic       btn_right;
  logic       btn_down;
  logic       btn_rot;
  logic       btn_start;
  logic       btn_pause;
  logic [7:0] core_score;
  logic       core_game_over;
  logic       core_rst_n;
  logic       drop_tick;
  logic       k_left;
  logic       k_right;
  logic       k_down;
  logic       k_rot;
  logic [2:0] state;
  logic [3:0] level;

  // Environment side: drives buttons and core status, observes commands.
  modport master (
    output btn_left, btn_right, btn_down, btn_rot, btn_start, btn_pause,
    output core_score, core_game_over,
    input  core_rst_n, drop_tick, k_left, k_right, k_down, k_rot, state, level
  );

  // Controller side.
  modport slave (
    input  btn_left, btn_right, btn_down, btn_rot, btn_start, btn_pause,
    input  core_score, core_game_over,
    output core_rst_n, drop_tick, k_left, k_right, k_down, k_rot, state, level
  );
endinterface

// File: rtl/tetris_game_ctrl.sv
// Game sequencer for tetris_core: game-state FSM, core reset, level-scaled gravity
// tick, button edge/auto-repeat scheduling and one-command-per-clock arbitration.
// Optional macro SOFT_DROP_RESET_EN: an issued k_down restarts the gravity period.
module tetris_game_ctrl #(
  parameter int unsigned BASE_DROP_CYC   = 50000000,
  parameter int unsigned DROP_STEP_CYC   = 4000000,
  parameter int unsigned MIN_DROP_CYC    = 5000000,
  parameter int unsigned REPEAT_DLY_CYC  = 12500000,
  parameter int unsigned REPEAT_CYC      = 2500000,
  parameter int unsigned LINES_PER_LEVEL = 10,
  parameter int unsigned MAX_LEVEL       = 9,
  parameter int unsigned CLR_CYC         = 4
) (
  input logic               clk,
  input logic               rst,
  tetris_game_ctrl_if.slave bus
);

  localparam int unsigned GW = $clog2(BASE_DROP_CYC + 1);
  localparam int unsigned RW = $clog2(((REPEAT_DLY_CYC > REPEAT_CYC) ?
                                       REPEAT_DLY_CYC : REPEAT_CYC) + 1);
  localparam int unsigned CW = $clog2(CLR_CYC + 1);
  localparam int unsigned LW = $clog2(LINES_PER_LEVEL + 1);

  // Command vector order doubles as priority: drop, rot, down, left, right.
  localparam int unsigned IDrop = 0;
  localparam int unsigned IRot  = 1;
  localparam int unsigned IDown = 2;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StClr   = 3'd1,
    StPlay  = 3'd2,
    StPause = 3'd3,
    StOver  = 3'd4
  } state_e;

  state_e             state_q;
  logic               core_rst_n_q;
  logic [4:0]         pulse_q, pend_q;
  logic [5:0]         btn_prev_q;     // {pause, start, rot, down, left, right}
  logic [GW-1:0]      grav_q;
  logic [CW-1:0]      clr_q;
  logic [LW-1:0]      lines_q;
  logic [3:0]         level_q;
  logic [7:0]         score_q;
  logic [2:0][RW-1:0] rep_q;          // repeat timers: 0 down, 1 left, 2 right
  logic [2:0]         rep_first_q;    // next repeat still waits the initial delay

  logic [5:0]         btn_now, btn_edge;
  logic [31:0]        lvl_step, period;
  logic               grav_hit;
  logic [GW-1:0]      grav_nxt;
  logic [2:0][RW-1:0] rep_nxt;
  logic [2:0]         rep_first_nxt;
  logic [4:0]         set, pend_all, pick, pend_nxt;
  logic               found;

  assign btn_now  = {bus.btn_pause, bus.btn_start, bus.btn_rot,
                     bus.btn_down, bus.btn_left, bus.btn_right};
  assign btn_edge = btn_now & ~btn_prev_q;

  // Play-state next values: gravity, repeat timers, request flags and arbitration.
  always_comb begin
    lvl_step = 32'(level_q) * DROP_STEP_CYC;
    if (BASE_DROP_CYC <= MIN_DROP_CYC || lvl_step >= BASE_DROP_CYC - MIN_DROP_CYC) begin
      period = MIN_DROP_CYC;
    end else begin
      period = BASE_DROP_CYC - lvl_step;
    end
    // >= rather than == so a level-up that shortens the period still fires at once.
    grav_hit = (32'(grav_q) + 32'd1) >= period;

    set      = '0;
    grav_nxt = grav_q + GW'(1);
    if (grav_hit) begin
      grav_nxt  = '0;
      set[IDrop] = 1'b1;
    end
    set[IRot] = btn_edge[3];

    rep_nxt       = rep_q;
    rep_first_nxt = rep_first_q;
    for (int r = 0; r < 3; r++) begin
      if (!btn_now[2-r]) begin
        rep_nxt[r]       = '0;
        rep_first_nxt[r] = 1'b1;
      end else if (btn_edge[2-r]) begin
        rep_nxt[r]       = RW'(1);
        rep_first_nxt[r] = 1'b1;
        set[2+r]         = 1'b1;
      end else if (rep_q[r] == (rep_first_q[r] ? RW'(REPEAT_DLY_CYC - 1)
                                                : RW'(REPEAT_CYC - 1))) begin
        rep_nxt[r]       = '0;
        rep_first_nxt[r] = 1'b0;
        set[2+r]         = 1'b1;
      end else begin
        rep_nxt[r] = rep_q[r] + RW'(1);
      end
    end

    pend_all = pend_q | set;
    pick     = '0;
    found    = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (pend_all[i] && !found) begin
        pick[i] = 1'b1;
        found   = 1'b1;
      end
    end
    pend_nxt = pend_all & ~pick;
`ifdef SOFT_DROP_RESET_EN
    if (pick[IDown]) begin
      grav_nxt        = '0;
      pend_nxt[IDrop] = 1'b0;
    end
`endif
  end

  // Game-state FSM with all counters, flags and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      core_rst_n_q <= 1'b0;
      pulse_q      <= '0;
      pend_q       <= '0;
      btn_prev_q   <= '0;
      grav_q       <= '0;
      clr_q        <= '0;
      lines_q      <= '0;
      level_q      <= '0;
      score_q      <= '0;
      rep_q        <= '0;
      rep_first_q  <= '1;
    end else begin
      btn_prev_q <= btn_now;
      score_q    <= bus.core_score;
      pulse_q    <= '0;
      case (state_q)
        StIdle: begin
          if (btn_edge[4]) begin
            state_q <= StClr;
            clr_q   <= '0;
          end
        end
        StClr: begin
          grav_q      <= '0;
          level_q     <= '0;
          lines_q     <= '0;
          rep_q       <= '0;
          rep_first_q <= '1;
          pend_q      <= '0;
          if (clr_q == CW'(CLR_CYC - 1)) begin
            state_q      <= StPlay;
            core_rst_n_q <= 1'b1;
          end else begin
            clr_q <= clr_q + CW'(1);
          end
        end
        StPlay: begin
          grav_q      <= grav_nxt;
          rep_q       <= rep_nxt;
          rep_first_q <= rep_first_nxt;
          if (bus.core_score != score_q) begin
            if (lines_q == LW'(LINES_PER_LEVEL - 1)) begin
              lines_q <= '0;
              if (level_q < 4'(MAX_LEVEL)) level_q <= level_q + 4'd1;
            end else begin
              lines_q <= lines_q + LW'(1);
            end
          end
          // Leaving PLAY drops this cycle's command so no pulse shows outside PLAY.
          if (bus.core_game_over) begin
            state_q <= StOver;
            pend_q  <= '0;
          end else if (btn_edge[5]) begin
            state_q <= StPause;
            pend_q  <= '0;
          end else begin
            pend_q  <= pend_nxt;
            pulse_q <= pick;
          end
        end
        StPause: begin
          pend_q <= '0;
          if (btn_edge[5]) state_q <= StPlay;
        end
        StOver: begin
          if (btn_edge[4]) begin
            state_q      <= StClr;
            clr_q        <= '0;
            core_rst_n_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.core_rst_n = core_rst_n_q;
  assign bus.drop_tick  = pulse_q[0];
  assign bus.k_rot      = pulse_q[1];
  assign bus.k_down     = pulse_q[2];
  assign bus.k_left     = pulse_q[3];
  assign bus.k_right    = pulse_q[4];
  assign bus.state      = state_q;
  assign bus.level      = level_q;

endmodule

// File: tb/tb_tetris_game_ctrl.sv
// Bench for tetris_game_ctrl: a cycle model derived from the game rules checked
// every cycle, plus directed scenarios with hand-computed timings.
module tb_tetris_game_ctrl;
  localparam int BASE = 100, STEP = 10, MIN = 20, RDLY = 30, REP = 8;
  localparam int LPL = 2, MAXL = 9, CLRC = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  tetris_game_ctrl_if bus ();

  tetris_game_ctrl #(
    .BASE_DROP_CYC  (BASE),
    .DROP_STEP_CYC  (STEP),
    .MIN_DROP_CYC   (MIN),
    .REPEAT_DLY_CYC (RDLY),
    .REPEAT_CYC     (REP),
    .LINES_PER_LEVEL(LPL),
    .MAX_LEVEL      (MAXL),
    .CLR_CYC        (CLRC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Pulses indexed by priority: 0 drop, 1 rot, 2 down, 3 left, 4 right.
  logic [4:0] dut_pulse;
  assign dut_pulse = {bus.k_right, bus.k_left, bus.k_down, bus.k_rot, bus.drop_tick};

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         m_state, m_clr, m_grav, m_level, m_lines;
  int         m_age[3];        // play cycles since press, -1 when not held
  logic [4:0] m_pend, m_pulse;
  logic [5:0] m_prev;
  logic [7:0] m_score_prev;

  function automatic int period_of(input int lvl);
    int p;
    p = BASE - lvl * STEP;
    if (p < MIN) p = MIN;
    return p;
  endfunction

  // Model advances on the same edge as the DUT from the same sampled inputs.
  always @(posedge clk or posedge rst) begin
    logic [5:0] b, e;
    logic [4:0] ev;
    if (rst) begin
      m_state = 0; m_clr = 0; m_grav = 0; m_level = 0; m_lines = 0;
      m_age = '{-1, -1, -1};
      m_pend = '0; m_pulse = '0; m_prev = '0; m_score_prev = '0;
    end else begin
      b = {bus.btn_pause, bus.btn_start, bus.btn_rot, bus.btn_down, bus.btn_left, bus.btn_right};
      e = b & ~m_prev;
      m_pulse = '0;
      case (m_state)
        0: if (e[4]) begin m_state = 1; m_clr = 0; end
        1: begin
          m_grav = 0; m_level = 0; m_lines = 0; m_pend = '0;
          m_age = '{-1, -1, -1};
          m_clr++;
          if (m_clr == CLRC) m_state = 2;
        end
        2: begin
          ev = '0;
          if (m_grav >= period_of(m_level) - 1) begin ev[0] = 1'b1; m_grav = 0; end
          else m_grav++;
          ev[1] = e[3];
          for (int r = 0; r < 3; r++) begin
            if (!b[2-r]) m_age[r] = -1;
            else if (e[2-r]) begin m_age[r] = 0; ev[2+r] = 1'b1; end
            else if (m_age[r] >= 0) begin
              m_age[r]++;
              if (m_age[r] >= RDLY - 1 && (m_age[r] - (RDLY - 1)) % REP == 0) ev[2+r] = 1'b1;
            end
          end
          m_pend = m_pend | ev;
          for (int i = 0; i < 5; i++) begin
            if (m_pend[i]) begin m_pulse[i] = 1'b1; m_pend[i] = 1'b0; break; end
          end
`ifdef SOFT_DROP_RESET_EN
          if (m_pulse[2]) begin m_grav = 0; m_pend[0] = 1'b0; end
`endif
          if (bus.core_score != m_score_prev) begin
            m_lines++;
            if (m_lines == LPL) begin
              m_lines = 0;
              if (m_level < MAXL) m_level++;
            end
          end
          if (bus.core_game_over) begin m_state = 4; m_pulse = '0; m_pend = '0; end
          else if (e[5]) begin m_state = 3; m_pulse = '0; m_pend = '0; end
        end
        3: begin m_pend = '0; if (e[5]) m_state = 2; end
        4: if (e[4]) begin m_state = 1; m_clr = 0; end
        default: m_state = 0;
      endcase
      m_prev = b;
      m_score_prev = bus.core_score;
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("state", 32'(bus.state), 32'(m_state));
      check("core_rst_n", 32'(bus.core_rst_n), 32'(m_state >= 2));
      check("level", 32'(bus.level), 32'(m_level));
      check("pulses", 32'(dut_pulse), 32'(m_pulse));
      check("one_pulse", 32'($countones(dut_pulse) <= 1), 32'd1);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Cycles from the current negedge until pulse idx is seen (bound if never).
  task automatic wait_pulse(input int idx, input int bound, output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!dut_pulse[idx] && k < bound);
  endtask

  initial begin
    int k, n;
    int q[$];
    int exp_left[5];
    logic [4:0] exp_burst[4];
    exp_left  = '{1, 30, 38, 46, 54};
    exp_burst = '{5'b00001, 5'b00010, 5'b01000, 5'b10000};

    bus.btn_left = 0; bus.btn_right = 0; bus.btn_down = 0; bus.btn_rot = 0;
    bus.btn_start = 0; bus.btn_pause = 0; bus.core_score = 8'd0; bus.core_game_over = 0;
    #1 rst = 1'b1;
    tick(3);
    chk_en = 1'b1;
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_core_rst_n", 32'(bus.core_rst_n), 32'd0);
    check("rst_level", 32'(bus.level), 32'd0);
    rst = 1'b0;
    tick(2);

    // Start: CLR for four cycles with core held in reset, then gravity every 100.
    bus.btn_start = 1; tick(1); bus.btn_start = 0;
    check("clr_entry_state", 32'(bus.state), 32'd1);
    check("clr_entry_rst_n", 32'(bus.core_rst_n), 32'd0);
    n = 0;
    while (bus.state == 3'd1 && n < 20) begin n++; tick(1); end
    check("clr_length", 32'(n), 32'd4);
    check("play_state", 32'(bus.state), 32'd2);
    wait_pulse(0, 300, k);
    check("first_drop", 32'(k), 32'd100);
    wait_pulse(0, 300, k);
    check("drop_period", 32'(k), 32'd100);

    // Hold left for 60 cycles: press pulse then auto-repeats.
    bus.btn_left = 1;
    for (int i = 1; i <= 80; i++) begin
      tick(1);
      if (dut_pulse[3]) q.push_back(i);
      if (i == 60) bus.btn_left = 0;
    end
    check("left_count", 32'(q.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      check("left_time", (i < q.size()) ? 32'(q[i]) : 32'hffff_ffff, 32'(exp_left[i]));

    // Three key edges in the same cycle the gravity request fires.
    wait_pulse(0, 300, k);
    check("drop_before_burst", 32'(k), 32'd20);
    tick(99);
    bus.btn_left = 1; bus.btn_right = 1; bus.btn_rot = 1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check("burst_order", 32'(dut_pulse), 32'(exp_burst[i]));
    end
    bus.btn_left = 0; bus.btn_right = 0; bus.btn_rot = 0;
    tick(1);
    check("burst_end", 32'(dut_pulse), 32'd0);

    // Score changes raise the level every two lines; period drops to 80.
    bus.core_score = 8'd1; tick(3);
    bus.core_score = 8'd2; tick(2);
    check("level_after_2", 32'(bus.level), 32'd1);
    bus.core_score = 8'd3; tick(3);
    bus.core_score = 8'd4; tick(2);
    check("level_after_4", 32'(bus.level), 32'd2);
    wait_pulse(0, 300, k);
    wait_pulse(0, 300, k);
    check("period_level2", 32'(k), 32'd80);

    // Pause at gravity count 30, idle 500 cycles, resume: drop after 80-30 cycles.
    tick(30);
    bus.btn_pause = 1; tick(1); bus.btn_pause = 0;
    check("paused", 32'(bus.state), 32'd3);
    n = 0;
    repeat (500) begin tick(1); if (|dut_pulse) n++; end
    check("pause_silent", 32'(n), 32'd0);
    bus.btn_pause = 1;
    wait_pulse(0, 300, k);
    bus.btn_pause = 0;
    check("resume_drop", 32'(k), 32'd50);

    // Game over, then restart through CLR.
    bus.core_game_over = 1; tick(1); bus.core_game_over = 0;
    check("over_state", 32'(bus.state), 32'd4);
    check("over_rst_n", 32'(bus.core_rst_n), 32'd1);
    tick(3);
    check("over_hold", 32'(bus.state), 32'd4);
    bus.btn_start = 1; tick(1); bus.btn_start = 0;
    bus.core_score = 8'd0;
    check("restart_state", 32'(bus.state), 32'd1);
    check("restart_rst_n", 32'(bus.core_rst_n), 32'd0);
    n = 0;
    while (bus.state != 3'd2 && n < 20) begin n++; tick(1); end
    check("replay_state", 32'(bus.state), 32'd2);
    check("replay_level", 32'(bus.level), 32'd0);

    // Soft drop at gravity count 90.
    tick(90);
    bus.btn_down = 1; tick(1);
    check("k_down_pulse", 32'(dut_pulse), 32'b00100);
    bus.btn_down = 0;
    wait_pulse(0, 300, k);
`ifdef SOFT_DROP_RESET_EN
    check("drop_after_down", 32'(k), 32'd100);
`else
    check("drop_after_down", 32'(k), 32'd9);
`endif

    // Reset mid-game with a key edge in flight: nothing may come out.
    tick(5);
    bus.btn_rot = 1;
    #2 rst = 1'b1;
    n = 0;
    repeat (3) begin tick(1); if (|dut_pulse) n++; end
    bus.btn_rot = 0;
    rst = 1'b0;
    repeat (3) begin tick(1); if (|dut_pulse) n++; end
    check("reset_silent", 32'(n), 32'd0);
    check("reset_state", 32'(bus.state), 32'd0);
    check("reset_rst_n", 32'(bus.core_rst_n), 32'd0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
